fir_sample_scheduler: RTL

Sequencer between a streaming sample source and the FIR filter datapath. It buffers incoming samples in a small FIFO and issues them one at a time on the filter's `data_ready`/`modwait` handshake. It arbitrates filter time between sample processing and coefficient reloads, and returns each filtered result through a held valid/ack register. It sits beside the coefficient loader, in place of direct bus-driven `data_ready` generation.

---
 rtl/fir_sample_scheduler.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/fir_sample_scheduler.sv
// Sample FIFO, filter handshake sequencer and result holding register for the FIR datapath.
// Optional feature: define FIR_SCHED_STATS_EN to build the completed-sample counter.
module fir_sample_scheduler #(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        sample_valid,
    input  logic [15:0] sample_in,
    output logic        sample_ready,
    input  logic        coeff_req,
    output logic        coeff_grant,
    output logic        new_coefficient_set,
    output logic [15:0] sample_data,
    output logic        data_ready,
    input  logic        modwait,
    input  logic [15:0] fir_out,
    input  logic        err,
    output logic        result_valid,
    output logic [15:0] result_data,
    output logic        result_err,
    input  logic        result_ack,
    output logic        overrun,
    output logic        timeout_err,
    input  logic        clear_flags,
    output logic [15:0] sample_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {
        IDLE, ISSUE, BUSY, DONE, RELOAD_START, RELOAD_DONE
    } state_t;

    state_t        state_reg;
    logic [15:0]   fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0] count_reg, count_next;
    logic          sample_ready_reg;
    logic [15:0]   timer_reg;
    logic [15:0]   sample_data_reg;
    logic          data_ready_reg, coeff_grant_reg;
    logic          result_valid_reg, result_err_reg;
    logic [15:0]   result_data_reg;
    logic          overrun_reg, timeout_err_reg;
    logic          push, pop, fifo_empty, timed_state, timeout_hit, capture, overrun_set;

    assign fifo_empty  = (count_reg == '0);
    assign push        = sample_valid & sample_ready_reg;
    // Reload requests take priority, so a pop only happens when no reload is pending.
    assign pop         = (state_reg == IDLE) & ~coeff_req & ~fifo_empty;
    assign count_next  = count_reg + CW'(push) - CW'(pop);
    assign timed_state = (state_reg == BUSY) | (state_reg == DONE) |
                         (state_reg == RELOAD_START) | (state_reg == RELOAD_DONE);
    assign timeout_hit = timed_state & (timer_reg == 16'(TIMEOUT - 1));
    assign capture     = (state_reg == DONE) & ~modwait & ~timeout_hit;
    assign overrun_set = capture & result_valid_reg & ~result_ack;

    generate
        for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_fifo_entry
            always_ff @(posedge clk) begin
                if (push && wr_ptr_reg == AW'(gi))
                    fifo_mem[gi] <= sample_in;
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr_reg       <= '0;
            rd_ptr_reg       <= '0;
            count_reg        <= '0;
            sample_ready_reg <= 1'b1;
        end else begin
            if (push)
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            count_reg        <= count_next;
            sample_ready_reg <= (count_next != CW'(FIFO_DEPTH));
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_reg       <= IDLE;
            timer_reg       <= '0;
            sample_data_reg <= '0;
            data_ready_reg  <= 1'b0;
            coeff_grant_reg <= 1'b0;
        end else begin
            data_ready_reg  <= 1'b0;
            coeff_grant_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (coeff_req) begin
                        state_reg       <= RELOAD_START;
                        coeff_grant_reg <= 1'b1;
                        timer_reg       <= '0;
                    end else if (pop) begin
                        state_reg       <= ISSUE;
                        sample_data_reg <= fifo_mem[rd_ptr_reg];
                        data_ready_reg  <= 1'b1;
                    end
                end
                ISSUE: begin
                    state_reg <= BUSY;
                    timer_reg <= '0;
                end
                BUSY: begin
                    timer_reg <= timer_reg + 16'd1;
                    if (timeout_hit)  state_reg <= IDLE;
                    else if (modwait) state_reg <= DONE;
                end
                DONE: begin
                    timer_reg <= timer_reg + 16'd1;
                    if (timeout_hit || !modwait) state_reg <= IDLE;
                end
                RELOAD_START: begin
                    timer_reg <= timer_reg + 16'd1;
                    if (timeout_hit)  state_reg <= IDLE;
                    else if (modwait) state_reg <= RELOAD_DONE;
                end
                RELOAD_DONE: begin
                    timer_reg <= timer_reg + 16'd1;
                    if (timeout_hit || !modwait) state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Flag set events win over a simultaneous clear_flags.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            result_valid_reg <= 1'b0;
            result_data_reg  <= '0;
            result_err_reg   <= 1'b0;
            overrun_reg      <= 1'b0;
            timeout_err_reg  <= 1'b0;
        end else begin
            if (capture) begin
                result_valid_reg <= 1'b1;
                result_data_reg  <= fir_out;
                result_err_reg   <= err;
            end else if (result_ack) begin
                result_valid_reg <= 1'b0;
            end
            if (overrun_set)      overrun_reg <= 1'b1;
            else if (clear_flags) overrun_reg <= 1'b0;
            if (timeout_hit)      timeout_err_reg <= 1'b1;
            else if (clear_flags) timeout_err_reg <= 1'b0;
        end
    end

`ifdef FIR_SCHED_STATS_EN
    logic [15:0] sample_count_reg;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            sample_count_reg <= '0;
        else
            sample_count_reg <= (clear_flags ? 16'd0 : sample_count_reg) + 16'(capture);
    end

    assign sample_count = sample_count_reg;
`else
    assign sample_count = '0;
`endif

    assign sample_ready        = sample_ready_reg;
    assign coeff_grant         = coeff_grant_reg;
    assign new_coefficient_set = coeff_grant_reg;
    assign sample_data         = sample_data_reg;
    assign data_ready          = data_ready_reg;
    assign result_valid        = result_valid_reg;
    assign result_data         = result_data_reg;
    assign result_err          = result_err_reg;
    assign overrun             = overrun_reg;
    assign timeout_err         = timeout_err_reg;

endmodule
